sha_msg_sched: RTL and testbench
================================

# sha_msg_sched

Message-level scheduler between the byte-stream padder and the SHA-256 compression core. It watches the byte handshake to learn each message's length and derives the number of padded 512-bit blocks. It feeds each block to the core with a first-block (load IV) flag and returns the final 256-bit digest over a valid/ready port. Only one message is in flight at a time; `msg_hold` fences the next message until the current digest is consumed.

## Interface
- `CNT_W`, default 32: width of the message byte counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `byte_valid`, `byte_ready`, `byte_last` in 1 each: passive snoop of the padder byte handshake. Never driven by this block.
- `msg_hold` out 1: upstream ANDs `byte_valid` with `!msg_hold`.
- `blk_valid` in 1, `blk_ready` out 1, `blk_data` in 512: padded-block stream from the padder.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_first` out 1: load IV before compressing.
- `core_block` out 512: block held stable from `core_start` until `core_done`.
- `core_done` in 1: one-cycle pulse.
- `core_digest` in 256: valid in the `core_done` cycle.
- `dig_valid` out 1, `dig_ready` in 1, `dig_data` out 256: digest output.
- `len_err` out 1: sticky flag, byte counter overflowed.

## Operation
- FSM states: IDLE, WAIT_BLK, START, COMPRESS, DIGEST.
- IDLE → WAIT_BLK on the first byte handshake. The `byte_cnt` increment for that byte happens in the same cycle.
- WAIT_BLK:
  - `blk_ready`=1.
  - On `blk_valid`: latch `blk_data` into `core_block`, go to START.
- START: `core_start`=1 for exactly one cycle, `core_first`=(`blk_cnt`==0), `blk_cnt`+1, go to COMPRESS.
- COMPRESS: wait for `core_done`.
  - If `tot_known` and `blk_cnt`==`blk_tot`: latch `core_digest` into `dig_data`, go to DIGEST.
  - Otherwise go to WAIT_BLK.
- DIGEST:
  - `dig_valid`=1.
  - On `dig_ready`: clear `byte_cnt`, `blk_cnt`, `tot_known` and `msg_hold`, go to IDLE.
- Byte counting:
  - `byte_cnt` (CNT_W) increments on every `byte_valid`&&`byte_ready` in any state except DIGEST.
  - On a handshake with `byte_last`=1: `blk_tot` = ((L+8)>>6)+1, where L = count including that byte. Set `tot_known`=1 and `msg_hold`=1 (registered).
  - `blk_tot` is computed in CNT_W+1 bits.
- Handshakes that occur while `msg_hold`=1 are ignored.
- `byte_cnt` wrap sets `len_err`. `len_err` clears only on reset.
- Blocks may arrive before the last byte; `tot_known`=0 always routes COMPRESS → WAIT_BLK.
- Simultaneous events:
  - A last-byte handshake in the same cycle as `core_done` is applied first. The final-block test then uses the new `blk_tot`.
  - A `dig_ready` handshake and `byte_last` cannot coincide, because `msg_hold` gates the input.

## Timing
- Reset values: `blk_ready`, `core_start`, `core_first`, `msg_hold`, `dig_valid` and `len_err` = 0. `core_block` and `dig_data` = 0. FSM = IDLE.
- Block accept → `core_start`: 1 cycle.
- `core_done` → `dig_valid` (final block): 1 cycle.
- `core_done` → `blk_ready` (non-final block): 1 cycle.
- `dig_valid` holds with stable `dig_data` until `dig_ready`.
- `msg_hold` rises the cycle after the last-byte handshake. It falls the cycle after the digest handshake.
- `rst` asserted mid-message or mid-compress returns everything to reset values immediately. The core's in-progress work is discarded.

## Configuration
- `SHA_MSG_SCHED_PERF_EN` defined:
  - Adds output `perf_cycles` (32 bits).
  - Zeroed on the first-byte handshake; increments every cycle until `dig_valid` rises, then freezes until the next message.
  - Saturates at 32'hFFFFFFFF.
  - Reset value 0.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package `sha_pkg`:
  - State enum.
  - `BLK_W`=512, `DIG_W`=256, `LEN_PAD_BYTES`=8, `BLK_BYTES`=64.
  - The SHA-256 IV constants used by the core.
- Sub-module `sha_blk_count`: combinational L → `blk_tot` computation, parameterised by CNT_W.

## Test plan
- "abc" (3 bytes) → `blk_tot`=1; one `core_start` with `core_first`=1; `dig_data`=ba7816bf…f20015ad.
- 55 bytes → 1 block. 56 bytes → 2 blocks: the first has `core_first`=1, the second `core_first`=0.
- 120 bytes with `byte_last` on the cycle `core_done` ends block 1 → `blk_tot`=3; exactly 3 starts, then `dig_valid`.
- `dig_ready` held low for 10 cycles → `dig_valid`/`dig_data` stable and `msg_hold`=1. A byte handshake forced during hold leaves `byte_cnt` unchanged.
- `rst` pulsed in COMPRESS of block 2 of a 100-byte message → all outputs at reset values next cycle. A following "abc" produces the correct digest.
- PERF_EN build, "abc" with a 4-cycle core → `perf_cycles` nonzero and frozen after `dig_valid`. Non-PERF build has no `perf_cycles` port.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256 message scheduler and its compression core.
// Provides the scheduler state enum, block/digest geometry and the SHA-256 IV.
package sha_pkg;

  localparam int unsigned BLK_W         = 512;
  localparam int unsigned DIG_W         = 256;
  localparam int unsigned LEN_PAD_BYTES = 8;
  localparam int unsigned BLK_BYTES     = 64;

  // Initial hash value H0..H7, H0 in the most significant word
  localparam logic [DIG_W-1:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BLK,
    START,
    COMPRESS,
    DIGEST
  } state_e;

endpackage

// File: rtl/sha_blk_count.sv
// Padded block count for a message of len_i bytes:
//   blk_tot_o = ((len_i + LEN_PAD_BYTES) / BLK_BYTES) + 1
// computed one bit wider than the byte counter so it cannot overflow.
// Ports:
//   len_i     in  CNT_W    message length in bytes
//   blk_tot_o out CNT_W+1  number of 512-bit blocks after padding
module sha_blk_count
  import sha_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic [CNT_W-1:0] len_i,
  output logic [CNT_W:0]   blk_tot_o
);

  localparam int unsigned BLK_SH = $clog2(BLK_BYTES);

  logic [CNT_W:0] padded_c;

  assign padded_c  = (CNT_W+1)'(len_i) + (CNT_W+1)'(LEN_PAD_BYTES);
  assign blk_tot_o = (padded_c >> BLK_SH) + (CNT_W+1)'(1);

endmodule

// File: rtl/sha_msg_sched.sv
// Message-level scheduler between the byte padder and the SHA-256 core.
// Snoops the byte handshake to learn the message length, feeds padded blocks
// to the core with a first-block flag, and returns the digest over valid/ready.
// Optional: define SHA_MSG_SCHED_PERF_EN to add the perf_cycles counter port.
// Ports:
//   clk, rst                       clock, async active-high reset
//   byte_valid/ready/last          snooped padder byte handshake (inputs only)
//   msg_hold                       fences the next message until digest taken
//   blk_valid/blk_ready/blk_data   padded block stream from the padder
//   core_start/first/block         core command (block stable until core_done)
//   core_done/core_digest          core completion
//   dig_valid/dig_ready/dig_data   digest output
//   len_err                        sticky byte counter overflow
//   perf_cycles                    (perf build) cycles from first byte to digest
module sha_msg_sched
  import sha_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_valid,
  input  logic             byte_ready,
  input  logic             byte_last,
  output logic             msg_hold,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [BLK_W-1:0] blk_data,
  output logic             core_start,
  output logic             core_first,
  output logic [BLK_W-1:0] core_block,
  input  logic             core_done,
  input  logic [DIG_W-1:0] core_digest,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [DIG_W-1:0] dig_data,
  output logic             len_err
`ifdef SHA_MSG_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_cycles
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W:0]   blk_cnt_q, blk_cnt_d;
  logic [CNT_W:0]   blk_tot_q, blk_tot_d;
  logic             tot_known_q, tot_known_d;
  logic             msg_hold_q, msg_hold_d;
  logic             len_err_q, len_err_d;
  logic             blk_ready_q, blk_ready_d;
  logic             core_start_q, core_start_d;
  logic             core_first_q, core_first_d;
  logic             dig_valid_q, dig_valid_d;
  logic [BLK_W-1:0] core_block_q, core_block_d;
  logic [DIG_W-1:0] dig_data_q, dig_data_d;

  logic             byte_hs_c;
  logic             last_hs_c;
  logic [CNT_W-1:0] len_c;
  logic [CNT_W:0]   blk_tot_new_c;

  // Handshakes are ignored while fenced and while a digest is pending
  assign byte_hs_c = byte_valid && byte_ready && !msg_hold_q && (state_q != DIGEST);
  assign last_hs_c = byte_hs_c && byte_last;
  assign len_c     = byte_cnt_q + CNT_W'(1);

  sha_blk_count #(.CNT_W(CNT_W)) u_blk_count (
    .len_i     (len_c),
    .blk_tot_o (blk_tot_new_c)
  );

`ifdef SHA_MSG_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic        perf_run_q, perf_run_d;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    blk_cnt_d    = blk_cnt_q;
    blk_tot_d    = blk_tot_q;
    tot_known_d  = tot_known_q;
    msg_hold_d   = msg_hold_q;
    len_err_d    = len_err_q;
    core_block_d = core_block_q;
    dig_data_d   = dig_data_q;
    blk_ready_d  = 1'b0;
    core_start_d = 1'b0;
    core_first_d = 1'b0;
    dig_valid_d  = 1'b0;

    if (byte_hs_c) begin
      byte_cnt_d = len_c;
      if (byte_cnt_q == '1) len_err_d = 1'b1;
    end

    // Applied before the COMPRESS decision so a coincident core_done sees it
    if (last_hs_c) begin
      blk_tot_d   = blk_tot_new_c;
      tot_known_d = 1'b1;
      msg_hold_d  = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (byte_hs_c) state_d = WAIT_BLK;
      end
      WAIT_BLK: begin
        if (blk_valid) begin
          core_block_d = blk_data;
          state_d      = START;
        end
      end
      START: begin
        blk_cnt_d = blk_cnt_q + (CNT_W+1)'(1);
        state_d   = COMPRESS;
      end
      COMPRESS: begin
        if (core_done) begin
          if (tot_known_d && (blk_cnt_q == blk_tot_d)) begin
            dig_data_d = core_digest;
            state_d    = DIGEST;
          end else begin
            state_d = WAIT_BLK;
          end
        end
      end
      DIGEST: begin
        if (dig_ready) begin
          byte_cnt_d  = '0;
          blk_cnt_d   = '0;
          tot_known_d = 1'b0;
          msg_hold_d  = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it
    blk_ready_d  = (state_d == WAIT_BLK);
    core_start_d = (state_d == START);
    core_first_d = (state_d == START) && (blk_cnt_q == '0);
    dig_valid_d  = (state_d == DIGEST);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      blk_cnt_q    <= '0;
      blk_tot_q    <= '0;
      tot_known_q  <= 1'b0;
      msg_hold_q   <= 1'b0;
      len_err_q    <= 1'b0;
      blk_ready_q  <= 1'b0;
      core_start_q <= 1'b0;
      core_first_q <= 1'b0;
      dig_valid_q  <= 1'b0;
      core_block_q <= '0;
      dig_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      blk_cnt_q    <= blk_cnt_d;
      blk_tot_q    <= blk_tot_d;
      tot_known_q  <= tot_known_d;
      msg_hold_q   <= msg_hold_d;
      len_err_q    <= len_err_d;
      blk_ready_q  <= blk_ready_d;
      core_start_q <= core_start_d;
      core_first_q <= core_first_d;
      dig_valid_q  <= dig_valid_d;
      core_block_q <= core_block_d;
      dig_data_q   <= dig_data_d;
    end
  end

`ifdef SHA_MSG_SCHED_PERF_EN
  // Cycle counter: restarts on a message's first byte, freezes when the digest appears
  always_comb begin
    perf_d     = perf_q;
    perf_run_d = perf_run_q;
    if ((state_q == IDLE) && byte_hs_c) begin
      perf_d     = '0;
      perf_run_d = 1'b1;
    end else if (perf_run_q) begin
      if (perf_q != '1) perf_d = perf_q + 32'(1);
      if (state_d == DIGEST) perf_run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q     <= '0;
      perf_run_q <= 1'b0;
    end else begin
      perf_q     <= perf_d;
      perf_run_q <= perf_run_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

  assign msg_hold   = msg_hold_q;
  assign blk_ready  = blk_ready_q;
  assign core_start = core_start_q;
  assign core_first = core_first_q;
  assign core_block = core_block_q;
  assign dig_valid  = dig_valid_q;
  assign dig_data   = dig_data_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_sha_msg_sched.sv
// Self-checking bench for sha_msg_sched: a behavioural padder and SHA-256 core
// surround the scheduler; expected digests and first-block flags are queued
// when stimulus is driven and checked when the DUT produces them.
module tb_sha_msg_sched;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  logic rst;
  logic byte_valid, byte_ready, byte_last, msg_hold;
  logic blk_valid, blk_ready;
  logic [511:0] blk_data;
  logic core_start, core_first;
  logic [511:0] core_block;
  logic core_done;
  logic [255:0] core_digest;
  logic dig_valid, dig_ready;
  logic [255:0] dig_data;
  logic len_err;

  // Second instance with a tiny counter to reach the wrap boundary
  logic b2_valid;
  logic msg_hold2, blk_ready2, core_start2, core_first2, dig_valid2, len_err2;
  logic [511:0] core_block2;
  logic [255:0] dig_data2;
  logic [511:0] zero512 = '0;
  logic [255:0] zero256 = '0;

`ifdef SHA_MSG_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_cycles2;
`endif

  sha_msg_sched dut (
    .clk(clk), .rst(rst),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_last(byte_last),
    .msg_hold(msg_hold),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .core_start(core_start), .core_first(core_first), .core_block(core_block),
    .core_done(core_done), .core_digest(core_digest),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
    .len_err(len_err)
`ifdef SHA_MSG_SCHED_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  sha_msg_sched #(.CNT_W(4)) dut2 (
    .clk(clk), .rst(rst),
    .byte_valid(b2_valid), .byte_ready(byte_ready), .byte_last(1'b0),
    .msg_hold(msg_hold2),
    .blk_valid(1'b0), .blk_ready(blk_ready2), .blk_data(zero512),
    .core_start(core_start2), .core_first(core_first2), .core_block(core_block2),
    .core_done(1'b0), .core_digest(zero256),
    .dig_valid(dig_valid2), .dig_ready(1'b0), .dig_data(dig_data2),
    .len_err(len_err2)
`ifdef SHA_MSG_SCHED_PERF_EN
    , .perf_cycles(perf_cycles2)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- SHA-256 reference ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_comp(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1, ch, mj;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      ch = (e & f) ^ (~e & g);
      t1 = hh + s1 + ch + K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      mj = (a & b) ^ (a & c) ^ (b & c);
      t2 = s0 + mj;
      hh = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e,  h[95:64] + f,   h[63:32] + g,   h[31:0] + hh};
  endfunction

  // ---------------- padder model ----------------
  logic [7:0] msg [256];
  int msg_len;

  function automatic int nblk();
    return ((msg_len + 8) / 64) + 1;
  endfunction

  function automatic logic [511:0] pad_blk(input int b);
    logic [511:0] r;
    logic [63:0]  bits;
    logic [7:0]   v;
    int           tot, i;
    r    = '0;
    bits = 64'(msg_len) * 64'd8;
    tot  = nblk() * 64;
    for (int j = 0; j < 64; j++) begin
      i = b * 64 + j;
      if (i < msg_len)        v = msg[i];
      else if (i == msg_len)  v = 8'h80;
      else if (i >= tot - 8)  v = bits[8*(tot-1-i) +: 8];
      else                    v = 8'h00;
      r[511-8*j -: 8] = v;
    end
    return r;
  endfunction

  function automatic logic [255:0] exp_digest();
    logic [255:0] h;
    h = IV;
    for (int b = 0; b < nblk(); b++) h = sha_comp(h, pad_blk(b));
    return h;
  endfunction

  // ---------------- scoreboards ----------------
  logic [255:0] dig_exp_q [$];
  bit           first_exp_q [$];

  // ---------------- core model ----------------
  int           core_lat = 4;
  int           core_cnt;
  bit           core_busy;
  bit           done_pending;
  int           n_starts = 0;
  logic [255:0] core_h;
  logic [511:0] core_blk_lat;

  initial begin
    core_done = 1'b0; core_digest = '0; core_busy = 1'b0; done_pending = 1'b0;
    core_cnt = 0; core_h = '0; core_blk_lat = '0;
    forever begin
      bit ef;
      @(negedge clk);
      core_done = 1'b0;
      if (rst) begin
        core_busy    = 1'b0;
        done_pending = 1'b0;
      end else if (core_busy) begin
        chk("core_block_stable", 256'(core_block != core_blk_lat), 256'(0));
        chk("no_start_while_busy", 256'(core_start), 256'(0));
        core_cnt--;
        if (core_cnt == 1) done_pending = 1'b1;
        if (core_cnt == 0) begin
          core_done    = 1'b1;
          core_digest  = core_h;
          core_busy    = 1'b0;
          done_pending = 1'b0;
        end
      end else if (core_start) begin
        n_starts++;
        chk("start_expected", 256'(first_exp_q.size() != 0), 256'(1));
        if (first_exp_q.size() != 0) begin
          ef = first_exp_q.pop_front();
          chk("core_first", 256'(core_first), 256'(ef));
        end
        core_h       = sha_comp(core_first ? IV : core_h, core_block);
        core_blk_lat = core_block;
        core_busy    = 1'b1;
        core_cnt     = core_lat;
      end
    end
  end

  // ---------------- stimulus helpers (enter and leave at a negedge) ----------------
  int t0 = 0;

  task automatic send_bytes(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      if (i == 0) t0 = cyc;
      byte_valid = 1'b1;
      byte_last  = (i == msg_len - 1);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic send_blk(input int b);
    int n;
    n = 0;
    first_exp_q.push_back(b == 0);
    blk_valid = 1'b1;
    blk_data  = pad_blk(b);
    while (!blk_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("blk_ready_timeout", 256'(n < 500), 256'(1));
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  task automatic get_digest(input int hold, input bit poke);
    int           n, td;
    logic [255:0] exp;
    n = 0;
    while (!dig_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("dig_valid_timeout", 256'(n < 500), 256'(1));
    td  = cyc;
    exp = (dig_exp_q.size() != 0) ? dig_exp_q.pop_front() : '0;
`ifdef SHA_MSG_SCHED_PERF_EN
    chk("perf_at_digest", 256'(perf_cycles), 256'(td - t0 - 1));
`endif
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 256'(dig_valid), 256'(1));
      chk("hold_data", dig_data, exp);
      chk("hold_msg_hold", 256'(msg_hold), 256'(1));
      byte_valid = poke && (h == 3);
      byte_last  = poke && (h == 3);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    if (poke) chk("hold_byte_cnt", 256'(dut.byte_cnt_q), 256'(msg_len));
    dig_ready = 1'b1;
    chk("digest", dig_data, exp);
    @(negedge clk);
    dig_ready = 1'b0;
    chk("dig_valid_drop", 256'(dig_valid), 256'(0));
    chk("msg_hold_drop", 256'(msg_hold), 256'(0));
`ifdef SHA_MSG_SCHED_PERF_EN
    chk("perf_frozen", 256'(perf_cycles), 256'(td - t0 - 1));
`endif
  endtask

  task automatic run_msg(input int hold, input bit poke, input bit is_abc);
    int base;
    base = n_starts;
    dig_exp_q.push_back(is_abc ? ABC_DIGEST : exp_digest());
    send_bytes(0, msg_len);
    for (int b = 0; b < nblk(); b++) send_blk(b);
    get_digest(hold, poke);
    chk("start_count", 256'(n_starts - base), 256'(nblk()));
    chk("first_q_drained", 256'(first_exp_q.size()), 256'(0));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, 256'({blk_ready, core_start, core_first, msg_hold, dig_valid, len_err}), 256'(0));
    chk({tag, "_block"}, 256'(core_block != '0), 256'(0));
    chk({tag, "_dig"}, dig_data, 256'(0));
`ifdef SHA_MSG_SCHED_PERF_EN
    chk({tag, "_perf"}, 256'(perf_cycles), 256'(0));
`endif
  endtask

  task automatic load_abc();
    msg_len = 3;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; byte_valid = 1'b0; byte_ready = 1'b1; byte_last = 1'b0;
    blk_valid = 1'b0; blk_data = '0; dig_ready = 1'b0; b2_valid = 1'b0;
    msg_len = 0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Byte counter wrap on the 4-bit instance
    for (int i = 0; i < 15; i++) begin
      b2_valid = 1'b1;
      @(negedge clk);
    end
    b2_valid = 1'b0;
    chk("len_err_before_wrap", 256'(len_err2), 256'(0));
    b2_valid = 1'b1;
    @(negedge clk);
    b2_valid = 1'b0;
    chk("len_err_wrap", 256'(len_err2), 256'(1));
    b2_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    b2_valid = 1'b0;
    chk("len_err_sticky", 256'(len_err2), 256'(1));

    // "abc": single block, known digest
    load_abc();
    run_msg(0, 1'b0, 1'b1);

    // 55 bytes: largest single-block message
    msg_len = 55;
    for (int i = 0; i < 55; i++) msg[i] = 8'($urandom);
    run_msg(0, 1'b0, 1'b0);

    // 56 bytes: two blocks; digest held 10 cycles with a fenced byte poke
    msg_len = 56;
    for (int i = 0; i < 56; i++) msg[i] = 8'(i * 7 + 3);
    run_msg(10, 1'b1, 1'b0);

    // 120 bytes: last byte coincides with core_done of block 1
    begin
      int base;
      msg_len = 120;
      for (int i = 0; i < 120; i++) msg[i] = 8'(i);
      base = n_starts;
      dig_exp_q.push_back(exp_digest());
      send_bytes(0, 119);
      send_blk(0);
      n = 0;
      while (!done_pending && n < 100) begin
        @(posedge clk);
        n++;
      end
      chk("done_pending_timeout", 256'(n < 100), 256'(1));
      @(negedge clk);
      chk("core_done_aligned", 256'(core_done), 256'(1));
      byte_valid = 1'b1;
      byte_last  = 1'b1;
      @(negedge clk);
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      chk("blk_tot_120", 256'(dut.blk_tot_q), 256'(nblk()));
      chk("msg_hold_after_last", 256'(msg_hold), 256'(1));
      send_blk(1);
      send_blk(2);
      get_digest(0, 1'b0);
      chk("start_count_120", 256'(n_starts - base), 256'(3));
    end

    // 100 bytes: reset during compression of block 2
    msg_len = 100;
    for (int i = 0; i < 100; i++) msg[i] = 8'(255 - i);
    send_bytes(0, 100);
    send_blk(0);
    send_blk(1);
    @(negedge clk);
    chk("in_compress", 256'(dut.state_q), 256'(3));
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("mid_reset");
    rst = 1'b0;
    @(negedge clk);

    // "abc" again after the abort
    load_abc();
    run_msg(0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
